mc_control: RTL and testbench



---
 rtl/mc_control.sv | 198 +++++++++++++++++++
 tb/tb_mc_control.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control -- multi-cycle main control FSM for the MIPS-I core.
//
// Sequences the shared-memory datapath through fetch, decode, execute,
// memory and write-back. It stalls in FETCH, MEMRD and MEMWR until
// mem_ready is high. It supplies the 3-bit ALUOp consumed by the ALU
// control decoder.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (state -> RST)
//   opcode[5:0]  IR[31:26]; used in DECODE, MEMADR and EXEC_I
//   mem_ready    memory completes the current read/write this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   RegWrite, RegDst, ALUSrcA
//                datapath strobes/selects
//   ALUSrcB[1:0] 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   PCSource[1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   ALUOp[2:0]   000 use funct, 001 ADD, 010 AND
//   illegal_op   one-cycle pulse on an unsupported opcode
//   instr_done   one-cycle pulse in the final cycle of each instruction
//   state[3:0]   current state encoding (debug)
module mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC_R  = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_EXEC_I  = 4'd11,
        S_IWB     = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    state_t cur_state, next_state;

    always_ff @(posedge clk) begin
        if (reset)
            cur_state <= S_RST;
        else
            cur_state <= next_state;
    end

    assign state = cur_state;

    always_comb begin
        next_state  = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = 3'b000;
        illegal_op  = 1'b0;
        instr_done  = 1'b0;

        case (cur_state)
            S_RST: next_state = S_FETCH;

            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 3'b001;
                // IR load and PC+4 commit only when the fetch completes.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                next_state = mem_ready ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 3'b001;
                case (opcode)
                    OP_RTYPE:        next_state = S_EXEC_R;
                    OP_LW, OP_SW:    next_state = S_MEMADR;
                    OP_BEQ:          next_state = S_BRANCH;
                    OP_J:            next_state = S_JUMP;
                    OP_ADDI, OP_ANDI: next_state = S_EXEC_I;
                    default:         next_state = S_ILLEGAL;
                endcase
            end

            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 3'b001;
                next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                next_state = mem_ready ? S_MEMWB : S_MEMRD;
            end

            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end

            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                next_state = mem_ready ? S_FETCH : S_MEMWR;
            end

            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                next_state = S_RWB;
            end

            S_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end

            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end

            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end

            S_EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = (opcode == OP_ANDI) ? 3'b010 : 3'b001;
                next_state = S_IWB;
            end

            S_IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end

            S_ILLEGAL: begin
                illegal_op = 1'b1;
                instr_done = 1'b1;
            end

            // Unused encodings 14/15: outputs idle, recover to FETCH.
            default: next_state = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control -- directed bench for mc_control.
//
// Each call to cyc() describes one clock cycle: the reset/mem_ready applied
// during it, and the state and packed control word expected in it. Expected
// control words are composed by hand from the named bit constants below.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic       illegal_op, instr_done;
    logic [3:0] state;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned done_cnt = 0;

    mc_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .ALUOp      (ALUOp),
        .illegal_op (illegal_op),
        .instr_done (instr_done),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Packed control word layout:
    // 18 PCWrite 17 PCWriteCond 16 IorD 15 MemRead 14 MemWrite 13 MemtoReg
    // 12 IRWrite 11 RegWrite 10 RegDst 9 ALUSrcA 8:7 ALUSrcB 6:5 PCSource
    // 4:2 ALUOp 1 illegal_op 0 instr_done
    localparam logic [18:0] PCW      = 19'd1 << 18;
    localparam logic [18:0] PCWC     = 19'd1 << 17;
    localparam logic [18:0] IORD     = 19'd1 << 16;
    localparam logic [18:0] MR       = 19'd1 << 15;
    localparam logic [18:0] MW       = 19'd1 << 14;
    localparam logic [18:0] M2R      = 19'd1 << 13;
    localparam logic [18:0] IRW      = 19'd1 << 12;
    localparam logic [18:0] RW       = 19'd1 << 11;
    localparam logic [18:0] RDST     = 19'd1 << 10;
    localparam logic [18:0] SRCA     = 19'd1 << 9;
    localparam logic [18:0] SRCB_4   = 19'd1 << 7;
    localparam logic [18:0] SRCB_IMM = 19'd2 << 7;
    localparam logic [18:0] SRCB_SH  = 19'd3 << 7;
    localparam logic [18:0] PCS_OUT  = 19'd1 << 5;
    localparam logic [18:0] PCS_J    = 19'd2 << 5;
    localparam logic [18:0] OP_ADD   = 19'd1 << 2;
    localparam logic [18:0] OP_AND   = 19'd2 << 2;
    localparam logic [18:0] ILL      = 19'd1 << 1;
    localparam logic [18:0] DONE     = 19'd1;

    localparam logic [18:0] W_FETCH  = PCW | MR | IRW | SRCB_4 | OP_ADD;
    localparam logic [18:0] W_FSTALL = MR | SRCB_4 | OP_ADD;
    localparam logic [18:0] W_DEC    = SRCB_SH | OP_ADD;
    localparam logic [18:0] W_MEMADR = SRCA | SRCB_IMM | OP_ADD;

    logic [18:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                   IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource,
                   ALUOp, illegal_op, instr_done};

    always @(posedge clk)
        if (instr_done === 1'b1)
            done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // One cycle: called at a falling edge, applies inputs, checks, then
    // advances to the next falling edge.
    task automatic cyc(input string tag, input logic rs, input logic mr,
                       input logic [3:0] st, input logic [18:0] exp);
        reset     = rs;
        mem_ready = mr;
        #1;
        check({tag, ".state"}, {28'd0, state}, {28'd0, st});
        check({tag, ".ctrl"}, {13'd0, ctrl}, {13'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'b000000;
        @(negedge clk);

        // R-type: 0,1,2,7,8 then FETCH
        cyc("r.rst",   0, 1, 4'd0, '0);
        cyc("r.fetch", 0, 1, 4'd1, W_FETCH);
        cyc("r.dec",   0, 1, 4'd2, W_DEC);
        cyc("r.exec",  0, 1, 4'd7, SRCA);
        cyc("r.wb",    0, 1, 4'd8, RW | RDST | DONE);

        // lw with three stall cycles in MEMRD: 8 cycles total
        opcode = 6'b100011;
        cyc("lw.fetch", 0, 1, 4'd1, W_FETCH);
        cyc("lw.dec",   0, 1, 4'd2, W_DEC);
        cyc("lw.adr",   0, 1, 4'd3, W_MEMADR);
        cyc("lw.rd0",   0, 0, 4'd4, MR | IORD);
        cyc("lw.rd1",   0, 0, 4'd4, MR | IORD);
        cyc("lw.rd2",   0, 0, 4'd4, MR | IORD);
        cyc("lw.rd3",   0, 1, 4'd4, MR | IORD);
        cyc("lw.wb",    0, 1, 4'd5, RW | M2R | DONE);

        // sw with a FETCH stall, mem_ready low (ignored) in DECODE, MEMWR stall
        opcode = 6'b101011;
        cyc("sw.fstall", 0, 0, 4'd1, W_FSTALL);
        cyc("sw.fetch",  0, 1, 4'd1, W_FETCH);
        cyc("sw.dec",    0, 0, 4'd2, W_DEC);
        cyc("sw.adr",    0, 1, 4'd3, W_MEMADR);
        cyc("sw.wr0",    0, 0, 4'd6, MW | IORD);
        cyc("sw.wr1",    0, 1, 4'd6, MW | IORD | DONE);

        // andi
        opcode = 6'b001100;
        cyc("andi.fetch", 0, 1, 4'd1,  W_FETCH);
        cyc("andi.dec",   0, 1, 4'd2,  W_DEC);
        cyc("andi.exec",  0, 1, 4'd11, SRCA | SRCB_IMM | OP_AND);
        cyc("andi.wb",    0, 1, 4'd12, RW | DONE);

        // addi
        opcode = 6'b001000;
        cyc("addi.fetch", 0, 1, 4'd1,  W_FETCH);
        cyc("addi.dec",   0, 1, 4'd2,  W_DEC);
        cyc("addi.exec",  0, 1, 4'd11, SRCA | SRCB_IMM | OP_ADD);
        cyc("addi.wb",    0, 1, 4'd12, RW | DONE);

        // beq
        opcode = 6'b000100;
        cyc("beq.fetch", 0, 1, 4'd1, W_FETCH);
        cyc("beq.dec",   0, 1, 4'd2, W_DEC);
        cyc("beq.br",    0, 1, 4'd9, SRCA | OP_ADD | PCWC | PCS_OUT | DONE);

        // j
        opcode = 6'b000010;
        cyc("j.fetch", 0, 1, 4'd1,  W_FETCH);
        cyc("j.dec",   0, 1, 4'd2,  W_DEC);
        cyc("j.jump",  0, 1, 4'd10, PCW | PCS_J | DONE);

        // illegal opcode
        opcode = 6'b111111;
        cyc("ill.fetch", 0, 1, 4'd1,  W_FETCH);
        cyc("ill.dec",   0, 1, 4'd2,  W_DEC);
        cyc("ill.ill",   0, 1, 4'd13, ILL | DONE);

        // reset asserted during a MEMWR stall
        opcode = 6'b101011;
        cyc("rsw.fetch", 0, 1, 4'd1, W_FETCH);
        cyc("rsw.dec",   0, 1, 4'd2, W_DEC);
        cyc("rsw.adr",   0, 1, 4'd3, W_MEMADR);
        cyc("rsw.wr",    1, 0, 4'd6, MW | IORD);
        cyc("rsw.rst",   0, 0, 4'd0, '0);
        cyc("rsw.fetch2", 0, 1, 4'd1, W_FETCH);

        // one instr_done per completed instruction (aborted sw excluded)
        check("done_count", done_cnt, 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
